// File: rtl/shift_pkg.sv
// Shared encodings and defaults for the bit-serial shift/rotate sequencer.
package shift_pkg;

    localparam int unsigned WIDTH_DEF   = 32;
    localparam int unsigned SHAMT_W_DEF = 5;

    typedef enum logic [2:0] {
        OP_SHR  = 3'd0,
        OP_SHRA = 3'd1,
        OP_SHL  = 3'd2,
        OP_ROR  = 3'd3,
        OP_ROL  = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= 3'(OP_ROL);
    endfunction

endpackage

// File: rtl/shift_rotate_sequencer_step.sv
// Combinational one-bit step of the working register for the selected operation.
module shift_step_1
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] work,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] stepped
);

    always_comb begin
        stepped = work;
        case (op)
            3'(OP_SHR):  stepped = {1'b0, work[WIDTH-1:1]};
            3'(OP_SHRA): stepped = {work[WIDTH-1], work[WIDTH-1:1]};
            3'(OP_SHL):  stepped = {work[WIDTH-2:0], 1'b0};
            3'(OP_ROR):  stepped = {work[0], work[WIDTH-1:1]};
            3'(OP_ROL):  stepped = {work[WIDTH-2:0], work[WIDTH-1]};
            default:     stepped = work;
        endcase
    end

endmodule

// File: rtl/shift_rotate_sequencer.sv
// Multi-cycle shift/rotate controller: one bit position per clock, start/done handshake.
module shift_rotate_sequencer
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned SHAMT_W = SHAMT_W_DEF
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   operand,
    input  logic [SHAMT_W-1:0] amount,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [WIDTH-1:0]   result
);

    state_e             state, state_next;
    logic [WIDTH-1:0]   work;
    logic [WIDTH-1:0]   stepped;
    logic [SHAMT_W-1:0] count;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   result_q;
    logic               err_q;
    logic               accept;
    logic               immediate;
    logic               last_step;

    shift_step_1 #(.WIDTH(WIDTH)) u_step (
        .work    (work),
        .op      (op_q),
        .stepped (stepped)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DONE accepts a new start directly so back-to-back operations lose no cycle.
    always_comb begin
        accept     = 1'b0;
        immediate  = 1'b0;
        last_step  = 1'b0;
        state_next = state;
        case (state)
            IDLE, DONE: begin
                accept    = start;
                immediate = (amount == '0) || !op_legal(op);
                if (start) begin
                    state_next = immediate ? DONE : SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                last_step  = (count == SHAMT_W'(1));
                state_next = last_step ? DONE : SHIFT;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            work     <= '0;
            count    <= '0;
            op_q     <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            work  <= operand;
            count <= amount;
            op_q  <= op;
            err_q <= !op_legal(op);
            if (immediate) begin
                result_q <= operand;
            end
        end else if (state == SHIFT) begin
            work  <= stepped;
            count <= count - SHAMT_W'(1);
            if (last_step) begin
                result_q <= stepped;
            end
        end
    end

    assign busy   = (state == SHIFT);
    assign done   = (state == DONE);
    assign err    = err_q;
    assign result = result_q;

endmodule

// File: tb/tb_shift_rotate_sequencer.sv
// Scoreboard bench for shift_rotate_sequencer: driver queues expected results, monitor checks each done.
module tb_shift_rotate_sequencer;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned SHAMT_W = 5;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             err;
    } exp_t;

    logic               clk = 1'b0;
    logic               clr;
    logic               start;
    logic [2:0]         op;
    logic [WIDTH-1:0]   operand;
    logic [SHAMT_W-1:0] amount;
    logic               busy;
    logic               done;
    logic               err;
    logic [WIDTH-1:0]   result;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    shift_rotate_sequencer #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clk     (clk),
        .clr     (clr),
        .start   (start),
        .op      (op),
        .operand (operand),
        .amount  (amount),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .result  (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done cycle must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!clr && done) begin
                check("busy_with_done", 32'(busy), 32'd0);
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_done: got result 0x%08h with no pending operation", result);
                end else begin
                    e = exp_q.pop_front();
                    check("result", result, e.res);
                    check("err", 32'(err), 32'(e.err));
                end
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [WIDTH-1:0] val, input logic [SHAMT_W-1:0] amt,
                         input logic [WIDTH-1:0] exp_res, input logic exp_err);
        start   = 1'b1;
        op      = o;
        operand = val;
        amount  = amt;
        exp_q.push_back('{res: exp_res, err: exp_err});
    endtask

    // Called at the negedge just before the accepting edge; returns at the negedge where done is seen.
    task automatic wait_done(input string name, input int exp_lat, input int exp_busy);
        int lat = 0;
        int busy_cycles = 0;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 64) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_busy_cycles"}, 32'(busy_cycles), 32'(exp_busy));
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [WIDTH-1:0] val,
                          input logic [SHAMT_W-1:0] amt, input logic [WIDTH-1:0] exp_res,
                          input logic exp_err, input int exp_lat, input int exp_busy);
        @(negedge clk);
        issue(o, val, amt, exp_res, exp_err);
        wait_done(name, exp_lat, exp_busy);
    endtask

    initial begin
        clr     = 1'b1;
        start   = 1'b0;
        op      = '0;
        operand = '0;
        amount  = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_result", result, 32'd0);
        clr = 1'b0;

        run_op("rol1",   3'd4, 32'h8000_0001, 5'd1,  32'h0000_0003, 1'b0, 2,  1);
        run_op("shra31", 3'd1, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 32, 31);
        run_op("shr31",  3'd0, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0, 32, 31);
        run_op("ror0",   3'd3, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0, 1,  0);
        run_op("illegal6", 3'd6, 32'h1234_5678, 5'd9, 32'h1234_5678, 1'b1, 1, 0);
        run_op("rol4",   3'd4, 32'h1234_5678, 5'd4,  32'h2345_6781, 1'b0, 5,  4);
        run_op("shra4",  3'd1, 32'h4000_0000, 5'd4,  32'h0400_0000, 1'b0, 5,  4);
        run_op("illegal7", 3'd7, 32'hCAFE_F00D, 5'd0, 32'hCAFE_F00D, 1'b1, 1, 0);

        // Start pulsed mid-operation must be dropped.
        @(negedge clk);
        issue(3'd2, 32'h0000_000F, 5'd4, 32'h0000_00F0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start   = 1'b1;
        op      = 3'd4;
        operand = 32'hFFFF_0000;
        amount  = 5'd8;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        check("ignored_start_drained", 32'(exp_q.size()), 32'd0);

        // Abort with clr after five SHIFT cycles.
        @(negedge clk);
        start   = 1'b1;
        op      = 3'd4;
        operand = 32'hA5A5_A5A5;
        amount  = 5'd16;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", result, 32'd0);
        repeat (20) @(negedge clk);
        run_op("shl1", 3'd2, 32'h0000_0001, 5'd1, 32'h0000_0002, 1'b0, 2, 1);

        // Back-to-back: second start sampled in the DONE cycle with amount=0.
        run_op("ror4", 3'd3, 32'h0000_000F, 5'd4, 32'hF000_0000, 1'b0, 5, 4);
        issue(3'd4, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b0);
        wait_done("b2b_rol0", 1, 0);
        @(negedge clk);
        check("b2b_done_drops", 32'(done), 32'd0);

        repeat (4) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
